// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage with valid/ready on operand and write-back sides.
// Optional iterative shift-add multiplier for opcode 11, enabled by defining ALU_MUL_EN.
module alu_exec_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_dst,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [3:0]  wb_sel,
   output logic        wb_zero,
   output logic        wb_carry,
   output logic        wb_err,
   output logic        busy
);

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MUL   = 2'd1,
      S_MDONE = 2'd2,
      S_WB    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd3
   } state_t;
`endif

   state_t      state_q;
   logic        rdy_q;
   logic [31:0] wb_data_q;
   logic [3:0]  wb_sel_q;
   logic        wb_zero_q;
   logic        wb_carry_q;
   logic        wb_err_q;
   logic [33:0] res_d;
   logic        accept;

`ifdef ALU_MUL_EN
   logic [4:0]  cnt_q;
   logic [31:0] mul_a_q;
   logic [31:0] mul_b_q;
   logic [31:0] acc_q;
`endif

   // Returns {err, carry, data} for every single-cycle opcode; 11..15 are illegal here.
   function automatic logic [33:0] alu_eval(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic        [32:0] sum;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic        [31:0] d;
      logic               c;
      logic               e;
      sum = '0;
      sa  = a;
      sb  = b;
      d   = '0;
      c   = 1'b0;
      e   = 1'b0;
      case (op)
         4'd0: begin
            sum = {1'b0, a} + {1'b0, b};
            d   = sum[31:0];
            c   = sum[32];
         end
         4'd1: begin
            d = a - b;
            c = (a < b);
         end
         4'd2:    d = a & b;
         4'd3:    d = a | b;
         4'd4:    d = a ^ b;
         4'd5:    d = a << b[4:0];
         4'd6:    d = a >> b[4:0];
         4'd7:    d = $unsigned(sa >>> b[4:0]);
         4'd8:    d = {31'd0, (sa < sb)};
         4'd9:    d = {31'd0, (a < b)};
         4'd10:   d = a;
         default: e = 1'b1;
      endcase
      return {e, c, d};
   endfunction

   always_comb begin
      res_d    = alu_eval(in_op, in_a, in_b);
      in_ready = rdy_q && ((state_q == S_IDLE) || ((state_q == S_WB) && wb_ready));
      accept   = in_valid && in_ready;
   end

   assign wb_valid = (state_q == S_WB);
   assign busy     = (state_q != S_IDLE);
   assign wb_data  = wb_data_q;
   assign wb_sel   = wb_sel_q;
   assign wb_zero  = wb_zero_q;
   assign wb_carry = wb_carry_q;
   assign wb_err   = wb_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b0;
         wb_data_q  <= '0;
         wb_sel_q   <= '0;
         wb_zero_q  <= 1'b0;
         wb_carry_q <= 1'b0;
         wb_err_q   <= 1'b0;
`ifdef ALU_MUL_EN
         cnt_q      <= '0;
`endif
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            wb_sel_q <= in_dst;
`ifdef ALU_MUL_EN
            if (in_op == OP_MUL) begin
               state_q <= S_MUL;
               cnt_q   <= '0;
               acc_q   <= '0;
               mul_a_q <= in_a;
               mul_b_q <= in_b;
            end else
`endif
            begin
               state_q    <= S_WB;
               wb_data_q  <= res_d[31:0];
               wb_carry_q <= res_d[32];
               wb_err_q   <= res_d[33];
               wb_zero_q  <= (res_d[31:0] == 32'd0);
            end
         end else begin
            case (state_q)
               S_WB: if (wb_ready) state_q <= S_IDLE;
`ifdef ALU_MUL_EN
               // One shift-add step per cycle; the 32nd step hands off to the load cycle.
               S_MUL: begin
                  if (mul_b_q[0]) acc_q <= acc_q + mul_a_q;
                  mul_a_q <= mul_a_q << 1;
                  mul_b_q <= mul_b_q >> 1;
                  cnt_q   <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) state_q <= S_MDONE;
               end
               S_MDONE: begin
                  wb_data_q  <= acc_q;
                  wb_zero_q  <= (acc_q == 32'd0);
                  wb_carry_q <= 1'b0;
                  wb_err_q   <= 1'b0;
                  state_q    <= S_WB;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; MUL scenarios follow ALU_MUL_EN.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_dst;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [3:0]  wb_sel;
   logic        wb_zero;
   logic        wb_carry;
   logic        wb_err;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   // {valid, err, carry, zero, sel, data}
   logic [39:0] wbv;
   assign wbv = {wb_valid, wb_err, wb_carry, wb_zero, wb_sel, wb_data};

   alu_exec_stage dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_dst   (in_dst),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_data  (wb_data),
      .wb_sel   (wb_sel),
      .wb_zero  (wb_zero),
      .wb_carry (wb_carry),
      .wb_err   (wb_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one packet for exactly one edge; DUT must be ready.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] dst);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_dst   = dst;
      step();
      in_valid = 1'b0;
   endtask

   task automatic release_wb();
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0; in_dst = '0;
      step(); step();
      n_chk++;
      if ({in_ready, busy, wbv} !== 42'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=%h", {in_ready, busy, wbv}, 42'd0);
      end
      rst = 1'b0;
      step();
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_rise got=%b want=1", in_ready);
      end
   endtask

   task automatic test_add();
      issue(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
      n_chk++;
      if (wbv !== {4'b1011, 4'd3, 32'h0}) begin
         n_fail++;
         $display("FAIL add_wrap got=%h want=%h", wbv, {4'b1011, 4'd3, 32'h0});
      end
      release_wb();
   endtask

   task automatic test_sub_slt();
      issue(4'd1, 32'd5, 32'd7, 4'd1);
      n_chk++;
      if (wbv !== {4'b1010, 4'd1, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL sub_borrow got=%h want=%h", wbv, {4'b1010, 4'd1, 32'hFFFF_FFFE});
      end
      release_wb();
      issue(4'd8, 32'hFFFF_FFFF, 32'd0, 4'd2);
      n_chk++;
      if (wbv !== {4'b1000, 4'd2, 32'd1}) begin
         n_fail++;
         $display("FAIL slt_signed got=%h want=%h", wbv, {4'b1000, 4'd2, 32'd1});
      end
      release_wb();
      issue(4'd9, 32'hFFFF_FFFF, 32'd0, 4'd2);
      n_chk++;
      if (wbv !== {4'b1001, 4'd2, 32'd0}) begin
         n_fail++;
         $display("FAIL sltu got=%h want=%h", wbv, {4'b1001, 4'd2, 32'd0});
      end
      release_wb();
   endtask

   task automatic test_shift_logic();
      issue(4'd7, 32'h8000_0000, 32'd31, 4'd4);
      n_chk++;
      if (wbv !== {4'b1000, 4'd4, 32'hFFFF_FFFF}) begin
         n_fail++;
         $display("FAIL sra31 got=%h want=%h", wbv, {4'b1000, 4'd4, 32'hFFFF_FFFF});
      end
      release_wb();
      issue(4'd5, 32'd1, 32'h25, 4'd5);
      n_chk++;
      if (wbv !== {4'b1000, 4'd5, 32'h20}) begin
         n_fail++;
         $display("FAIL sll5 got=%h want=%h", wbv, {4'b1000, 4'd5, 32'h20});
      end
      release_wb();
      issue(4'd6, 32'h8000_1234, 32'hFFFF_FFE0, 4'd6);
      n_chk++;
      if (wbv !== {4'b1000, 4'd6, 32'h8000_1234}) begin
         n_fail++;
         $display("FAIL srl0 got=%h want=%h", wbv, {4'b1000, 4'd6, 32'h8000_1234});
      end
      release_wb();
      issue(4'd4, 32'hA5A5_0F0F, 32'h5A5A_0FF0, 4'd7);
      n_chk++;
      if (wbv !== {4'b1000, 4'd7, 32'hFFFF_00FF}) begin
         n_fail++;
         $display("FAIL xor got=%h want=%h", wbv, {4'b1000, 4'd7, 32'hFFFF_00FF});
      end
      release_wb();
      issue(4'd10, 32'hDEAD_BEEF, 32'd0, 4'd8);
      n_chk++;
      if (wbv !== {4'b1000, 4'd8, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL pass_a got=%h want=%h", wbv, {4'b1000, 4'd8, 32'hDEAD_BEEF});
      end
      release_wb();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_op    = 4'd2;
         in_a     = 32'hF0F0_0000 | 32'(i + 16'h11);
         in_b     = 32'h0FF0_00FF;
         in_dst   = 4'(i + 9);
         exp_d    = 32'h00F0_0000 | 32'(i + 16'h11);
         step();
         n_chk++;
         if ({in_ready, wbv} !== {1'b1, 4'b1000, 4'(i + 9), exp_d}) begin
            n_fail++;
            $display("FAIL b2b_%0d got=%h want=%h", i, {in_ready, wbv}, {1'b1, 4'b1000, 4'(i + 9), exp_d});
         end
      end
      in_valid = 1'b0;
      step();
      n_chk++;
      if ({wb_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_drain got=%b want=00", {wb_valid, busy});
      end
      wb_ready = 1'b0;
      issue(4'd3, 32'h0000_1200, 32'h0000_0034, 4'd12);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_op    = 4'd0;
         in_a     = 32'd99;
         in_b     = 32'd1;
         in_dst   = 4'd1;
         step();
         n_chk++;
         if ({in_ready, wbv} !== {1'b0, 4'b1000, 4'd12, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got=%h want=%h", i, {in_ready, wbv}, {1'b0, 4'b1000, 4'd12, 32'h0000_1234});
         end
      end
      in_valid = 1'b0;
      release_wb();
      n_chk++;
      if (wb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release got=%b want=0", wb_valid);
      end
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul();
      int k;
      issue(4'd11, 32'h0001_0001, 32'h0001_0001, 4'd10);
      k = 0;
      while (!wb_valid && k < 40) begin
         if (k == 10) begin
            n_chk++;
            if ({busy, in_ready} !== 2'b10) begin
               n_fail++;
               $display("FAIL mul_busy got=%b want=10", {busy, in_ready});
            end
         end
         step();
         k++;
      end
      n_chk++;
      if (k !== 33 || wbv !== {4'b1000, 4'd10, 32'h0002_0001}) begin
         n_fail++;
         $display("FAIL mul_result cycles=%0d want=33 got=%h want=%h", k, wbv, {4'b1000, 4'd10, 32'h0002_0001});
      end
      release_wb();
      issue(4'd11, 32'd7, 32'd0, 4'd2);
      k = 0;
      while (!wb_valid && k < 40) begin
         step();
         k++;
      end
      n_chk++;
      if (k !== 33 || wbv !== {4'b1001, 4'd2, 32'd0}) begin
         n_fail++;
         $display("FAIL mul_zero cycles=%0d want=33 got=%h want=%h", k, wbv, {4'b1001, 4'd2, 32'd0});
      end
      release_wb();
      issue(4'd11, 32'd3, 32'd5, 4'd1);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      n_chk++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL mul_rst_ready got=%b want=10", {in_ready, busy});
      end
      k = 0;
      for (int i = 0; i < 40; i++) begin
         if (wb_valid) k++;
         step();
      end
      n_chk++;
      if (k !== 0) begin
         n_fail++;
         $display("FAIL mul_rst_no_wb got=%0d valid cycles want=0", k);
      end
   endtask
`else
   task automatic test_mul();
      issue(4'd11, 32'h0001_0001, 32'h0001_0001, 4'd10);
      n_chk++;
      if (wbv !== {4'b1101, 4'd10, 32'd0}) begin
         n_fail++;
         $display("FAIL mul_disabled got=%h want=%h", wbv, {4'b1101, 4'd10, 32'd0});
      end
      release_wb();
   endtask
`endif

   task automatic test_illegal();
      issue(4'd14, 32'h1234_5678, 32'h1, 4'd15);
      n_chk++;
      if (wbv !== {4'b1101, 4'd15, 32'd0}) begin
         n_fail++;
         $display("FAIL illegal_op got=%h want=%h", wbv, {4'b1101, 4'd15, 32'd0});
      end
      release_wb();
      issue(4'd0, 32'd2, 32'd3, 4'd0);
      n_chk++;
      if (wbv !== {4'b1000, 4'd0, 32'd5}) begin
         n_fail++;
         $display("FAIL illegal_clear got=%h want=%h", wbv, {4'b1000, 4'd0, 32'd5});
      end
      release_wb();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_shift_logic();
      test_back_to_back();
      test_mul();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
